// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: buffers producer bytes and launches
// them one at a time, pacing on tx_busy and flagging a transmitter that never starts.
module uart_tx_fifo #(
  parameter int DEPTH         = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  input  logic [7:0]                 wr_data,
  output logic                       wr_ready,
  input  logic                       flush,
  output logic                       tx_data_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       tx_timeout,
  output logic [1:0]                 fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] WAIT_START = 2'd1;
  localparam logic [1:0] WAIT_DONE  = 2'd2;

  // Handshake: a byte is written on a rising edge where wr_valid && wr_ready.
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          timeout_q, timeout_d;
  logic          push, pop;

  assign empty         = (level_q == '0);
  assign full          = (level_q == LW'(DEPTH));
  assign wr_ready      = !full && !flush;
  assign push          = wr_valid && wr_ready;
  // flush wins over a launch decision on the same edge
  assign pop           = (state_q == IDLE) && !empty && !tx_busy && !flush;
  assign level         = level_q;
  assign tx_data_valid = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign tx_timeout    = timeout_q;
  assign fsm_state     = state_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_valid_d = 1'b0;
    tx_data_d  = tx_data_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d  = mem_q[rd_ptr_q];
          tx_valid_d = 1'b1;
          cnt_d      = CW'(START_TIMEOUT);
          state_d    = WAIT_START;
        end
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
          // The launched byte is dropped on expiry; it is not retried.
          if (cnt_q == CW'(1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) timeout_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random traffic, with a byte-queue
// reference model and a negedge monitor that scores every launch strobe.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int START_TIMEOUT = 8;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       flush;
  logic       tx_data_valid;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       tx_timeout;
  logic [1:0] fsm_state;

  uart_tx_fifo #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .flush(flush), .tx_data_valid(tx_data_valid),
    .tx_data(tx_data), .tx_busy(tx_busy), .level(level), .empty(empty),
    .full(full), .tx_timeout(tx_timeout), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int max_level = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transmitter model ----------------
  // mode 0: busy tied low, 1: busy rises 1 cycle after a strobe for hold_len cycles, 2: forced high
  int busy_mode = 0;
  int hold_len = 10;
  int hold = 0;
  bit pend = 0;

  always @(posedge clk) begin
    #1;
    if (busy_mode == 0) begin
      tx_busy = 1'b0; pend = 0; hold = 0;
    end else if (busy_mode == 2) begin
      tx_busy = 1'b1;
    end else begin
      if (pend) begin
        tx_busy = 1'b1; hold = hold_len; pend = 0;
      end else if (hold > 0) begin
        hold--;
        tx_busy = (hold != 0);
      end else begin
        tx_busy = 1'b0;
      end
      if (tx_data_valid) pend = 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_valid = 0;
  bit prev_busy = 0;
  logic [7:0] last_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_valid = 0;
      prev_busy = 0;
      last_data = 8'h00;
    end else begin
      if (tx_data_valid) begin
        strobes++;
        chk("strobe_single_cycle", 32'(prev_valid), 0);
        chk("launch_with_busy_low", 32'(prev_busy), 0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe act=%0h exp=none t=%0t", tx_data, $time);
        end else begin
          last_data = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(last_data));
        end
      end else begin
        chk("tx_data_hold", 32'(tx_data), 32'(last_data));
      end
      chk("level", 32'(level), 32'(exp_q.size()));
      chk("empty", 32'(empty), 32'(exp_q.size() == 0));
      chk("full", 32'(full), 32'(exp_q.size() == DEPTH));
      chk("wr_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH && !flush));
      if (int'(level) > max_level) max_level = int'(level);
      if (flush) exp_q.delete();
      else if (wr_valid && exp_q.size() < DEPTH) exp_q.push_back(wr_data);
      prev_valid = tx_data_valid;
      prev_busy = tx_busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] d);
    int n = 0;
    wr_valid = 1'b1;
    wr_data = d;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      n++;
      if (n > 500) begin
        chk("write_accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && fsm_state == 2'd0 && !tx_busy && !tx_data_valid) break;
      n++;
      if (n > budget) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget);
    int n = 0;
    while (fsm_state != s) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        chk("state_wait_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_tx_valid"}, 32'(tx_data_valid), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_timeout"}, 32'(tx_timeout), 0);
    chk({tag, "_state_idle"}, 32'(fsm_state), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int s0;
    int lat;
    int k;
    rst_n = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_busy = 1'b0;
    #12;
    check_reset_values("por");
    chk("por_wr_ready", 32'(wr_ready), 1);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // single byte, launch latency
    busy_mode = 1; hold_len = 10;
    write_byte(8'hA5);
    lat = 0;
    while (!tx_data_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_launch_latency", 32'(lat), 2);
    wait_drain(200);
    chk("single_level_zero", 32'(level), 0);
    chk("single_empty", 32'(empty), 1);

    // fill to DEPTH with busy held
    busy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    s0 = strobes;
    for (int i = 0; i < DEPTH; i++) write_byte(8'(i));
    @(negedge clk);
    chk("burst_full", 32'(full), 1);
    chk("burst_level", 32'(level), DEPTH);
    chk("burst_wr_ready", 32'(wr_ready), 0);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    wr_valid = 1'b0;
    busy_mode = 1; hold_len = 3;
    wait_drain(1000);
    chk("burst_strobe_count", 32'(strobes - s0), DEPTH);

    // pointer wrap
    max_level = 0;
    hold_len = 4;
    for (int i = 0; i < 10; i++) write_byte(8'($urandom_range(0, 255)));
    wait_drain(1000);
    for (int i = 0; i < 12; i++) write_byte(8'($urandom_range(0, 255)));
    wait_drain(1000);
    chk("wrap_max_level_le_12", 32'(max_level <= 12), 1);

    // start timeout
    busy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    write_byte(8'h3C);
    lat = 0;
    while (!tx_data_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("timeout_clear_at_launch", 32'(tx_timeout), 0);
    k = 0;
    while (!tx_timeout && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_delay", 32'(k), START_TIMEOUT);
    @(posedge clk); #1;
    s0 = strobes;
    write_byte(8'h5A);
    wait_drain(200);
    chk("after_timeout_launch", 32'(strobes - s0), 1);

    // flush during WAIT_DONE
    busy_mode = 1; hold_len = 30;
    for (int i = 0; i < 6; i++) write_byte(8'($urandom_range(0, 255)));
    wait_state(2'd2, 100);
    @(negedge clk);
    chk("preflush_level", 32'(level), 5);
    chk("preflush_timeout_sticky", 32'(tx_timeout), 1);
    @(posedge clk); #1;
    flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE;
    @(posedge clk); #1;
    flush = 1'b0; wr_valid = 1'b0;
    s0 = strobes;
    @(negedge clk);
    chk("flush_level", 32'(level), 0);
    chk("flush_timeout_cleared", 32'(tx_timeout), 0);
    repeat (45) @(posedge clk);
    #1;
    chk("flush_no_strobe", 32'(strobes - s0), 0);
    chk("flush_back_idle", 32'(fsm_state), 0);

    // async reset mid-frame
    hold_len = 20;
    for (int i = 0; i < 4; i++) write_byte(8'($urandom_range(0, 255)));
    wait_state(2'd2, 100);
    #3 rst_n = 1'b0;
    #1;
    check_reset_values("async");
    chk("async_wr_ready", 32'(wr_ready), 1);
    busy_mode = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    s0 = strobes;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_no_strobe", 32'(strobes - s0), 0);

    // random traffic
    busy_mode = 1;
    for (int c = 0; c < 400; c++) begin
      hold_len = $urandom_range(1, 6);
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_data = 8'($urandom_range(0, 255));
      flush = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; flush = 1'b0;
    wait_drain(2000);
    chk("random_final_empty", 32'(empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
